s_pn_frame: RTL and testbench
=============================

S_PN_FRAME -- requirements
Module: s_pn_frame

Interface
REQ-001 SHALL have parameter N, default 48, frame length in bits, legal range 16..64.
REQ-002 SHALL have parameter LSB_FIRST, default 0; 0 places the first received bit in output_n[N-1], 1 places it in output_n[0].
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-low reset.
REQ-005 SHALL have port enable, input, 1; bit sampling occurs only in cycles where it is 1.
REQ-006 SHALL have port input_1, input, 1, serial data line, idle high.
REQ-007 SHALL have port output_n, output, N, last complete frame in parallel form.
REQ-008 SHALL have port push, output, 1, one-cycle strobe marking a new output_n.
REQ-009 SHALL have port crc_ok, output, 1, CRC7 check result for the frame marked by push.
REQ-010 SHALL have port frame_err, output, 1, end bit of that frame was 0.
REQ-011 SHALL have port busy, output, 1, high while a frame is being shifted in.

Function
REQ-012 SHALL implement a two-state FSM: IDLE and SHIFT.
REQ-013 In IDLE with enable=1 and input_1=0, the FSM SHALL capture that 0 as frame bit 1 (the start bit), set the bit counter to 1 and go to SHIFT.
REQ-014 In IDLE, input_1=1 or enable=0 SHALL leave the FSM in IDLE with no state change.
REQ-015 In SHIFT, each enable=1 cycle SHALL sample one bit and increment the counter; enable=0 cycles SHALL freeze the counter, shift register and CRC.
REQ-016 Sampling bit N SHALL return the FSM to IDLE.
REQ-017 push SHALL be 1 exactly in the cycle after bit N is sampled, with output_n, crc_ok and frame_err valid in that same cycle.
REQ-018 output_n, crc_ok and frame_err SHALL hold their values until the next push.
REQ-019 CRC7 (x^7+x^3+1, initial value 0) SHALL be computed serially over frame bits 1..N-8.
REQ-020 crc_ok SHALL be 1 iff the computed CRC7 equals frame bits N-7..N-1, first received bit as the CRC MSB.
REQ-021 frame_err SHALL be 1 iff frame bit N is 0.
REQ-022 The cycle carrying push SHALL already be in IDLE and may accept a new start bit, giving back-to-back frames with zero gap.
REQ-023 busy SHALL equal 1 exactly when the FSM is in SHIFT.
REQ-024 The bit counter SHALL be ceil(log2(N+1)) bits wide and SHALL never wrap within a frame.

Reset
REQ-025 reset=0 at a clock edge SHALL force IDLE, counter=0, CRC=0, shift register=0, output_n=0, push=0, crc_ok=0, frame_err=0 and busy=0.
REQ-026 reset asserted mid-frame SHALL discard the partial frame, with no push in the cycle after reset is released.
REQ-027 reset SHALL take priority over enable and input_1.

Structure
REQ-028 Package sd_pkg SHALL hold the CRC7 polynomial constant (7'h09), the FSM state enumeration and the CRC width constant.
REQ-029 Serial CRC7 SHALL be a sub-module crc7_ser with ports clk, reset, clear, en, bit_in and crc[6:0].
REQ-030 The top level SHALL contain the FSM, counter, shift register and output registers only.

Verification
REQ-031 With N=48, LSB_FIRST=0, send 0x400000000095 MSB-first -> push for one cycle, output_n=0x400000000095, crc_ok=1, frame_err=0.
REQ-032 Send 0x48000001AA87 immediately followed, with no gap, by 0x400000000095 -> two push pulses exactly 48 cycles apart, both with crc_ok=1.
REQ-033 Send 0x48000001AA87 with bit 20 inverted -> push asserted, crc_ok=0; then send 0x48000001AA86 -> frame_err=1, crc_ok=1.
REQ-034 Drop enable to 0 for 5 cycles after bit 10 of 0x400000000095 -> push arrives 5 cycles later than normal, same output_n, crc_ok=1.
REQ-035 Assert reset=0 for one cycle at bit 20 of a frame -> all outputs 0, no push; the following 0x400000000095 is then received correctly.
REQ-036 Hold input_1=1 for 200 cycles, then rerun with N=16 and LSB_FIRST=1 -> no push or busy during the idle run; in the N=16 run the first received bit appears in output_n[0].

Source files
------------

// File: rtl/sd_pkg.sv
// Shared constants and types for the serial frame receiver and its CRC7 engine.
package sd_pkg;
    localparam int CRC_W = 7;
    localparam logic [CRC_W-1:0] CRC7_POLY = 7'h09;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;
endpackage

// File: rtl/crc7_ser.sv
// Bit-serial CRC7 (x^7+x^3+1). A clear in the same cycle as en restarts the
// CRC from zero and folds bit_in in immediately.
module crc7_ser
    import sd_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             en,
    input  logic             bit_in,
    output logic [CRC_W-1:0] crc
);

    logic [CRC_W-1:0] base;
    logic [CRC_W-1:0] stepped;

    always_comb begin
        base    = clear ? '0 : crc;
        stepped = {base[CRC_W-2:0], 1'b0} ^ ((bit_in ^ base[CRC_W-1]) ? CRC7_POLY : '0);
    end

    always_ff @(posedge clk) begin
        if (!reset)     crc <= '0;
        else if (en)    crc <= stepped;
        else if (clear) crc <= '0;
    end

endmodule

// File: rtl/s_pn_frame.sv
// Serial-to-parallel frame receiver: start bit detect, N-bit capture,
// CRC7 check over the payload and end-bit check, one-cycle push per frame.
module s_pn_frame
    import sd_pkg::*;
#(
    parameter int N         = 48,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic         input_1,
    output logic [N-1:0] output_n,
    output logic         push,
    output logic         crc_ok,
    output logic         frame_err,
    output logic         busy
);

    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);
    localparam logic [CW-1:0] CRC_END  = CW'(N - 8);

    state_t           state, state_next;
    logic [CW-1:0]    cnt, cnt_next;
    logic [N-1:0]     sr, sr_next;
    logic             sample, last, crc_clr, crc_en;
    logic [CRC_W-1:0] crc, crc_rx;
    logic             end_bit;

    crc7_ser u_crc (
        .clk   (clk),
        .reset (reset),
        .clear (crc_clr),
        .en    (crc_en),
        .bit_in(input_1),
        .crc   (crc)
    );

    // cnt counts bits already taken, so the bit being sampled is cnt+1.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        sample     = 1'b0;
        last       = 1'b0;
        crc_clr    = 1'b0;
        crc_en     = 1'b0;
        case (state)
            IDLE: begin
                if (enable && !input_1) begin
                    sample     = 1'b1;
                    crc_clr    = 1'b1;
                    crc_en     = 1'b1;
                    cnt_next   = CW'(1);
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (enable) begin
                    sample   = 1'b1;
                    crc_en   = (cnt < CRC_END);
                    cnt_next = cnt + CW'(1);
                    if (cnt == LAST_IDX) begin
                        last       = 1'b1;
                        cnt_next   = '0;
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        sr_next = sr;
        if (sample) sr_next = LSB_FIRST ? {input_1, sr[N-1:1]} : {sr[N-2:0], input_1};
    end

    // Received CRC field (frame bits N-7..N-1, first one as MSB) and end bit.
    always_comb begin
        crc_rx = '0;
        for (int i = 0; i < CRC_W; i++)
            crc_rx[CRC_W-1-i] = LSB_FIRST ? sr_next[N-8+i] : sr_next[7-i];
        end_bit = LSB_FIRST ? sr_next[N-1] : sr_next[0];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            sr        <= '0;
            output_n  <= '0;
            push      <= 1'b0;
            crc_ok    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            sr    <= sr_next;
            push  <= last;
            if (last) begin
                output_n  <= sr_next;
                crc_ok    <= (crc == crc_rx);
                frame_err <= ~end_bit;
            end
        end
    end

    assign busy = (state == SHIFT);

endmodule

// File: tb/tb_s_pn_frame.sv
// Bench for s_pn_frame: N=48 MSB-first and N=16 LSB-first instances on one clock.
module tb_s_pn_frame;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, en_a, din_a, en_b, din_b;
    logic [47:0] out_a;
    logic [15:0] out_b;
    logic        push_a, ok_a, err_a, busy_a;
    logic        push_b, ok_b, err_b, busy_b;

    s_pn_frame #(.N(48), .LSB_FIRST(1'b0)) dut_a (
        .clk(clk), .reset(reset), .enable(en_a), .input_1(din_a),
        .output_n(out_a), .push(push_a), .crc_ok(ok_a), .frame_err(err_a), .busy(busy_a));

    s_pn_frame #(.N(16), .LSB_FIRST(1'b1)) dut_b (
        .clk(clk), .reset(reset), .enable(en_b), .input_1(din_b),
        .output_n(out_b), .push(push_b), .crc_ok(ok_b), .frame_err(err_b), .busy(busy_b));

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [63:0] data;
        logic        ok;
        logic        err;
    } ev_t;

    ev_t evs_a[512];
    ev_t evs_b[512];
    int  na = 0, nb = 0, busy_cnt_a = 0, busy_cnt_b = 0;
    int  ra = 0, rb = 0;

    always @(negedge clk) begin
        if (push_a && na < 512) begin
            evs_a[na] = '{cyc, 64'(out_a), ok_a, err_a};
            na = na + 1;
        end
        if (push_b && nb < 512) begin
            evs_b[nb] = '{cyc, 64'(out_b), ok_b, err_b};
            nb = nb + 1;
        end
        if (busy_a) busy_cnt_a = busy_cnt_a + 1;
        if (busy_b) busy_cnt_b = busy_cnt_b + 1;
    end

    // Reference: CRC7 as the remainder of msg(x)*x^7 divided by x^7+x^3+1.
    function automatic logic [6:0] crc7_ref(input logic [63:0] msg, input int nbits);
        logic [63:0] r;
        r = msg << 7;
        for (int i = nbits + 6; i >= 7; i--)
            if (r[i]) r = r ^ (64'h89 << (i - 7));
        return r[6:0];
    endfunction

    function automatic logic [15:0] rev16(input logic [15:0] v);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) r[i] = v[15-i];
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic e, input logic d);
        if (sel) begin en_b = e; din_b = d; end
        else begin en_a = e; din_a = d; end
    endtask

    // Bits go out in frame order: frame bit k is v[n-k].
    task automatic send(input bit sel, input logic [63:0] v, input int n, input int pause_at,
                        input int pause_len, input bit idle_after, output int start);
        start = -1;
        for (int k = 1; k <= n; k++) begin
            if (k == pause_at + 1)
                for (int p = 0; p < pause_len; p++) begin
                    @(negedge clk);
                    drive(sel, 1'b0, 1'($urandom_range(0, 1)));
                end
            @(negedge clk);
            drive(sel, 1'b1, v[n-k]);
            if (k == 1) start = cyc;
        end
        if (idle_after) begin
            @(negedge clk);
            drive(sel, 1'b1, 1'b1);
        end
        #1;
    endtask

    task automatic expect_push(input bit sel, input string name, input logic [63:0] data,
                               input logic ok, input logic err, output int pc);
        ev_t ev;
        for (int i = 0; i < 8 && (sel ? (nb <= rb) : (na <= ra)); i++) begin
            @(negedge clk);
            #1;
        end
        pc = -1;
        if (sel ? (nb <= rb) : (na <= ra)) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: no push seen, expected one", name);
        end else begin
            if (sel) begin ev = evs_b[rb]; rb++; end
            else begin ev = evs_a[ra]; ra++; end
            pc = ev.cyc;
            chk({name, " data"}, ev.data, data);
            chk({name, " crc_ok"}, 64'(ev.ok), 64'(ok));
            chk({name, " frame_err"}, 64'(ev.err), 64'(err));
        end
    endtask

    typedef struct {
        logic [47:0] frame;
        logic        ok;
        logic        err;
    } vec_t;

    vec_t tbl[4];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int st, st2, pc, pc2, snap;
        logic [63:0] v, msg;
        logic [6:0]  c;

        tbl[0] = '{48'h400000000095, 1'b1, 1'b0};
        tbl[1] = '{48'h48000001AA87, 1'b1, 1'b0};
        tbl[2] = '{48'h48000001AA87 ^ 48'h000010000000, 1'b0, 1'b0};  // frame bit 20 flipped
        tbl[3] = '{48'h48000001AA86, 1'b1, 1'b1};

        // Reset state, with inputs trying to start a frame
        reset = 1'b0; en_a = 1'b1; din_a = 1'b0; en_b = 1'b1; din_b = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst out_a", 64'(out_a), 0);
        chk("rst push/ok/err/busy a", {push_a, ok_a, err_a, busy_a}, 0);
        chk("rst out_b", 64'(out_b), 0);
        chk("rst busy_b", 64'(busy_b), 0);
        reset = 1'b1; din_a = 1'b1; din_b = 1'b1;
        repeat (2) @(negedge clk);

        // Table vectors, each checked for data, flags and start-to-push latency
        for (int t = 0; t < 4; t++) begin
            send(1'b0, 64'(tbl[t].frame), 48, 0, 0, 1'b1, st);
            expect_push(1'b0, $sformatf("tbl%0d", t), 64'(tbl[t].frame), tbl[t].ok, tbl[t].err, pc);
            chk($sformatf("tbl%0d latency", t), 64'(pc - st), 48);
        end
        repeat (3) @(negedge clk);
        chk("single push pulses", 64'(na - ra), 0);

        // Back-to-back frames, no gap
        send(1'b0, 64'h48000001AA87, 48, 0, 0, 1'b0, st);
        send(1'b0, 64'h400000000095, 48, 0, 0, 1'b1, st2);
        expect_push(1'b0, "b2b first", 64'h48000001AA87, 1'b1, 1'b0, pc);
        expect_push(1'b0, "b2b second", 64'h400000000095, 1'b1, 1'b0, pc2);
        chk("b2b spacing", 64'(pc2 - pc), 48);
        chk("b2b start gap", 64'(st2 - st), 48);
        repeat (3) @(negedge clk);
        chk("b2b push count", 64'(na - ra), 0);

        // Enable drop for 5 cycles after bit 10
        send(1'b0, 64'h400000000095, 48, 10, 5, 1'b1, st);
        expect_push(1'b0, "stall", 64'h400000000095, 1'b1, 1'b0, pc);
        chk("stall latency", 64'(pc - st), 53);

        // Reset pulse while bit 20 is on the line
        send(1'b0, 64'h400000000095, 20, 0, 0, 1'b0, st);
        @(negedge clk); reset = 1'b0; din_a = 1'b0;
        @(negedge clk); reset = 1'b1; din_a = 1'b1;
        #1;
        chk("midrst out_a", 64'(out_a), 0);
        chk("midrst push/ok/err/busy", {push_a, ok_a, err_a, busy_a}, 0);
        repeat (60) @(negedge clk);
        chk("midrst no push", 64'(na - ra), 0);
        send(1'b0, 64'h400000000095, 48, 0, 0, 1'b1, st);
        expect_push(1'b0, "after midrst", 64'h400000000095, 1'b1, 1'b0, pc);

        // Randomized frames against the reference model
        for (int r = 0; r < 12; r++) begin
            msg = {$urandom, $urandom} & 64'h7F_FFFF_FFFF;
            c = crc7_ref(msg, 40);
            v = (msg << 8) | 64'({c, 1'b1});
            case ($urandom_range(0, 3))
                0: v = v ^ (64'h2 << $urandom_range(0, 6));
                1: v = v & ~64'h1;
                default: ;
            endcase
            send(1'b0, v, 48, 0, 0, 1'b1, st);
            expect_push(1'b0, $sformatf("rand%0d", r), v & 64'hFFFF_FFFF_FFFF,
                        crc7_ref(v >> 8, 40) == v[7:1], !v[0], pc);
        end

        // Long idle: no busy, no push
        snap = busy_cnt_a;
        repeat (200) @(negedge clk);
        chk("idle busy_a", 64'(busy_cnt_a - snap), 0);
        chk("idle push_a", 64'(na - ra), 0);
        chk("idle busy_b", 64'(busy_cnt_b), 0);

        // N=16 LSB-first instance: first received bit lands in output_n[0]
        for (int r = 0; r < 6; r++) begin
            msg = 64'($urandom_range(0, 127));
            c = crc7_ref(msg, 8);
            v = (msg << 8) | 64'({c, 1'b1});
            if (r == 5) v = v & ~64'h1;
            send(1'b1, v, 16, 0, 0, 1'b1, st);
            expect_push(1'b1, $sformatf("n16_%0d", r), 64'(rev16(v[15:0])), 1'b1, !v[0], pc);
            chk($sformatf("n16_%0d latency", r), 64'(pc - st), 16);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
